// File: rtl/bank_burst_ctrl.sv
// Burst initiator for one Bank: accepts read/write commands, issues BL wrapped column beats after CWL/CL.
// Optional burst chop (BL/2 beats, cmd_bc port) is enabled by defining BANK_BURST_CHOP_EN.
module bank_burst_ctrl #(
    parameter int DEVICE_WIDTH = 4,
    parameter int COLWIDTH     = 10,
    parameter int CHWIDTH      = 5,
    parameter int BL           = 8,
    parameter int CL           = 5,
    parameter int CWL          = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_wr,
    input  logic [CHWIDTH-1:0]      cmd_row,
    input  logic [COLWIDTH-1:0]     cmd_col,
`ifdef BANK_BURST_CHOP_EN
    input  logic                    cmd_bc,
`endif
    input  logic [DEVICE_WIDTH-1:0] wdata,
    output logic                    wr_data_req,
    output logic [DEVICE_WIDTH-1:0] rdata,
    output logic                    rdata_valid,
    output logic                    bank_rd_o_wr,
    output logic [DEVICE_WIDTH-1:0] bank_dqin,
    input  logic [DEVICE_WIDTH-1:0] bank_dqout,
    output logic [CHWIDTH-1:0]      bank_row,
    output logic [COLWIDTH-1:0]     bank_column
);

    localparam int BW     = $clog2(BL) + 1;
    localparam int MAXLAT = (CL > CWL) ? CL : CWL;
    localparam int LATW   = $clog2(MAXLAT + 1);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] WR_WAIT  = 3'd1;
    localparam logic [2:0] WR_BURST = 3'd2;
    localparam logic [2:0] RD_WAIT  = 3'd3;
    localparam logic [2:0] RD_BURST = 3'd4;

    logic [2:0]                state_q, state_d;
    logic [LATW-1:0]           lat_q, lat_d;
    logic [BW-1:0]             beat_q, beat_d;
    logic [CHWIDTH-1:0]        row_q, row_d;
    logic [COLWIDTH-1:0]       col_q, col_d;
    logic                      rvalid_q;
    logic [DEVICE_WIDTH-1:0]   rhold_q;
    logic                      bc_q;
    logic                      accept;
    logic [BW-1:0]             last_beat;
    logic [COLWIDTH-1:0]       wrap_mask;

    assign accept = cmd_valid && (state_q == IDLE);

`ifdef BANK_BURST_CHOP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bc_q <= 1'b0;
        end else if (accept) begin
            bc_q <= cmd_bc;
        end
    end
`else
    assign bc_q = 1'b0;
`endif

    assign last_beat = bc_q ? BW'(BL/2 - 1) : BW'(BL - 1);
    assign wrap_mask = bc_q ? COLWIDTH'(BL/2 - 1) : COLWIDTH'(BL - 1);

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        beat_d  = beat_q;
        row_d   = row_q;
        col_d   = col_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    row_d  = cmd_row;
                    col_d  = cmd_col;
                    beat_d = '0;
                    if (cmd_wr) begin
                        if (CWL == 1) begin
                            state_d = WR_BURST;
                        end else begin
                            state_d = WR_WAIT;
                            lat_d   = LATW'(CWL - 2);
                        end
                    end else begin
                        if (CL == 2) begin
                            state_d = RD_BURST;
                        end else begin
                            state_d = RD_WAIT;
                            lat_d   = LATW'(CL - 3);
                        end
                    end
                end
            end
            WR_WAIT, RD_WAIT: begin
                if (lat_q == '0) begin
                    state_d = (state_q == WR_WAIT) ? WR_BURST : RD_BURST;
                end else begin
                    lat_d = lat_q - LATW'(1);
                end
            end
            WR_BURST, RD_BURST: begin
                if (beat_q == last_beat) begin
                    state_d = IDLE;
                    beat_d  = '0;
                end else begin
                    beat_d = beat_q + BW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            lat_q    <= '0;
            beat_q   <= '0;
            row_q    <= '0;
            col_q    <= '0;
            rvalid_q <= 1'b0;
            rhold_q  <= '0;
        end else begin
            state_q  <= state_d;
            lat_q    <= lat_d;
            beat_q   <= beat_d;
            row_q    <= row_d;
            col_q    <= col_d;
            rvalid_q <= (state_q == RD_BURST);
            rhold_q  <= rdata;
        end
    end

    // Bank output is already registered, so rdata passes it through during the valid beat and holds otherwise.
    assign rdata        = rvalid_q ? bank_dqout : rhold_q;
    assign rdata_valid  = rvalid_q;
    assign cmd_ready    = (state_q == IDLE);
    assign wr_data_req  = (state_q == WR_BURST);
    assign bank_rd_o_wr = (state_q == WR_BURST);
    assign bank_dqin    = wdata;
    assign bank_row     = row_q;
    assign bank_column  = (col_q & ~wrap_mask) | ((col_q + COLWIDTH'(beat_q)) & wrap_mask);

endmodule

// File: tb/tb_bank_burst_ctrl.sv
// Randomized bench for bank_burst_ctrl: Bank memory model plus a cycle-scheduled reference of every beat.
module tb_bank_burst_ctrl;

    localparam int DW   = 4;
    localparam int COLW = 10;
    localparam int CHW  = 5;
    localparam int BL   = 8;
    localparam int CL   = 5;
    localparam int CWL  = 4;
    localparam int MEMN = 1 << (CHW + COLW);

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic            cmd_wr = 1'b0;
    logic [CHW-1:0]  cmd_row = '0;
    logic [COLW-1:0] cmd_col = '0;
    logic            cmd_bc = 1'b0;
    logic [DW-1:0]   wdata = '0;
    logic            wr_data_req;
    logic [DW-1:0]   rdata;
    logic            rdata_valid;
    logic            bank_rd_o_wr;
    logic [DW-1:0]   bank_dqin;
    logic [DW-1:0]   bank_dqout;
    logic [CHW-1:0]  bank_row;
    logic [COLW-1:0] bank_column;

    always #5 clk = ~clk;

    bank_burst_ctrl #(
        .DEVICE_WIDTH(DW), .COLWIDTH(COLW), .CHWIDTH(CHW),
        .BL(BL), .CL(CL), .CWL(CWL)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_row(cmd_row), .cmd_col(cmd_col),
`ifdef BANK_BURST_CHOP_EN
        .cmd_bc(cmd_bc),
`endif
        .wdata(wdata), .wr_data_req(wr_data_req),
        .rdata(rdata), .rdata_valid(rdata_valid),
        .bank_rd_o_wr(bank_rd_o_wr), .bank_dqin(bank_dqin), .bank_dqout(bank_dqout),
        .bank_row(bank_row), .bank_column(bank_column)
    );

    function automatic logic [DW-1:0] init_val(input int i);
        return DW'((i * 5) + (i / 7) + 3);
    endfunction

    // Bank model: write on the edge, synchronous read visible next cycle
    logic [DW-1:0] bank_mem [MEMN];
    logic [DW-1:0] dqout_q;
    logic          mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < MEMN; i++) bank_mem[i] <= init_val(i);
            mem_init <= 1'b1;
        end else begin
            if (bank_rd_o_wr) bank_mem[{bank_row, bank_column}] <= bank_dqin;
            dqout_q <= bank_mem[{bank_row, bank_column}];
        end
    end
    assign bank_dqout = dqout_q;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Reference: every accepted command is expanded into the cycles where each beat must appear
    logic [DW-1:0] shadow [MEMN];
    bit            shadow_init = 1'b0;
    int            waddr [int];
    int            raddr [int];
    logic [DW-1:0] rexp  [int];
    int            last_addr = -1;
    logic [DW-1:0] last_rdata = '0;

    always @(negedge clk) begin
        bit wr, rd;
        int n, start, c, base;
        if (!shadow_init) begin
            for (int i = 0; i < MEMN; i++) shadow[i] = init_val(i);
            shadow_init = 1'b1;
        end
        if (reset) begin
            chk("rst_ready", cmd_ready, 1);
            chk("rst_wr_data_req", wr_data_req, 0);
            chk("rst_rdata_valid", rdata_valid, 0);
            chk("rst_rd_o_wr", bank_rd_o_wr, 0);
            chk("rst_row", bank_row, 0);
            chk("rst_column", bank_column, 0);
            chk("rst_rdata", rdata, 0);
            waddr.delete(); raddr.delete(); rexp.delete();
            last_addr  = -1;
            last_rdata = '0;
        end else begin
            chk("cmd_ready", cmd_ready, cyc > last_addr);
            wr = waddr.exists(cyc);
            rd = raddr.exists(cyc);
            chk("wr_data_req", wr_data_req, wr);
            chk("rd_o_wr", bank_rd_o_wr, wr);
            if (wr) begin
                chk("wr_addr", {bank_row, bank_column}, waddr[cyc]);
                chk("dqin", bank_dqin, wdata);
                shadow[waddr[cyc]] = wdata;
            end
            if (rd) begin
                chk("rd_addr", {bank_row, bank_column}, raddr[cyc]);
                rexp[cyc + 1] = shadow[raddr[cyc]];
            end
            chk("rdata_valid", rdata_valid, rexp.exists(cyc));
            if (rexp.exists(cyc)) begin
                chk("rdata", rdata, rexp[cyc]);
                last_rdata = rexp[cyc];
            end else begin
                chk("rdata_hold", rdata, last_rdata);
            end
            if (cmd_valid && cmd_ready) begin
                n = BL;
`ifdef BANK_BURST_CHOP_EN
                if (cmd_bc) n = BL / 2;
`endif
                start = cmd_wr ? cyc + CWL : cyc + CL - 1;
                c     = int'(cmd_col);
                base  = c - (c % n);
                for (int i = 0; i < n; i++) begin
                    if (cmd_wr) waddr[start + i] = int'(cmd_row) * (1 << COLW) + base + ((c % n) + i) % n;
                    else        raddr[start + i] = int'(cmd_row) * (1 << COLW) + base + ((c % n) + i) % n;
                end
                last_addr = start + n - 1;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1 wdata = DW'($urandom);
        end
    end

    // Called at posedge+1; holds cmd_valid until accepted, returns at posedge+1 after acceptance
    task automatic send(input bit wr, input int row, input int col, input bit bc);
        bit ok;
        ok        = 1'b0;
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_row   = CHW'(row);
        cmd_col   = COLW'(col);
        cmd_bc    = bc;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("accept_timeout", ok, 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic drain();
        repeat (CL + BL + 4) @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt;
        int col;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        send(1, 3, 'h010, 0);
        send(0, 3, 'h010, 0);
        send(1, 3, 'h0F0, 0);
        send(0, 3, 'h0F6, 0);
        send(1, 5, 'h3FF, 0);
        send(0, 5, 'h3FF, 0);
        send(0, 3, 'h0F0, 0);
        send(1, 3, 'h0F0, 0);
        drain();

        send(1, 7, 'h100, 0);
        cnt = 0;
        for (int k = 0; k < 100 && cnt < 3; k++) begin
            @(negedge clk);
            if (wr_data_req) cnt++;
        end
        chk("beat_wait", cnt, 3);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("async_wr_data_req", wr_data_req, 0);
        chk("async_rd_o_wr", bank_rd_o_wr, 0);
        chk("async_ready", cmd_ready, 1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        send(0, 7, 'h100, 0);
        drain();

`ifdef BANK_BURST_CHOP_EN
        send(1, 2, 'h006, 1);
        send(0, 2, 'h006, 1);
        send(0, 2, 'h006, 0);
        drain();
`endif

        repeat (40) begin
            case ($urandom_range(3))
                0:       col = 'h3FF;
                1:       col = int'($urandom_range(15));
                default: col = int'($urandom_range((1 << COLW) - 1));
            endcase
`ifdef BANK_BURST_CHOP_EN
            send(bit'($urandom_range(1)), int'($urandom_range(3)), col, bit'($urandom_range(1)));
`else
            send(bit'($urandom_range(1)), int'($urandom_range(3)), col, 1'b0);
`endif
            repeat ($urandom_range(2)) @(posedge clk);
            #1;
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bank_burst_ctrl.md
Name: bank_burst_ctrl

Overview:
- Initiator for the Bank storage model: accepts one read or write burst command per handshake and drives the Bank's row, column, rd_o_wr and dqin.
- Generates BL consecutive column beats with DDR-style sequential wrap inside the BL-aligned column block.
- Applies write latency (CWL) and read latency (CL) relative to command acceptance.
- Returns read data with a valid strobe; sits between the chip-level command decoder and each Bank instance.

Parameters:
- DEVICE_WIDTH, 4, data bits per column location; must match the Bank.
- COLWIDTH, 10, column address width.
- CHWIDTH, 5, row address width of the modelled row set.
- BL, 8, burst length in beats; power of 2, 2..2**COLWIDTH.
- CL, 5, cycles from command acceptance to first rdata_valid; >=2.
- CWL, 4, cycles from command acceptance to first write beat; >=1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller idle and able to accept a command.
- cmd_wr  in  1  1 = write burst, 0 = read burst.
- cmd_row  in  CHWIDTH  target row.
- cmd_col  in  COLWIDTH  starting column.
- wdata  in  DEVICE_WIDTH  write beat data; must be valid while wr_data_req = 1.
- wr_data_req  out  1  wdata is consumed this cycle.
- rdata  out  DEVICE_WIDTH  read beat data.
- rdata_valid  out  1  rdata holds a valid beat.
- bank_rd_o_wr  out  1  to Bank: 0 = read, 1 = write.
- bank_dqin  out  DEVICE_WIDTH  to Bank write data.
- bank_dqout  in  DEVICE_WIDTH  from Bank; valid one cycle after its address (synchronous BRAM read).
- bank_row  out  CHWIDTH  to Bank row.
- bank_column  out  COLWIDTH  to Bank column.

Behaviour:
- Reset (asynchronous):
  - state = IDLE; cmd_ready = 1.
  - wr_data_req, rdata_valid, bank_rd_o_wr, bank_row, bank_column, rdata = 0.
- States: IDLE, WR_WAIT, WR_BURST, RD_WAIT, RD_BURST. A latency counter and a beat counter (log2(BL)+1 bits) drive the transitions.
- IDLE:
  - cmd_ready = 1 in IDLE only.
  - Acceptance cycle T0 = cmd_valid & cmd_ready; row, column, cmd_wr and the burst base are latched at T0.
  - cmd_wr = 1 goes to WR_WAIT (or directly to WR_BURST if CWL = 1); cmd_wr = 0 goes to RD_WAIT (or RD_BURST if CL = 2).
- Write timing:
  - WR_BURST occupies cycles T0+CWL .. T0+CWL+BL-1.
  - Each of these cycles: wr_data_req = 1, bank_rd_o_wr = 1, bank_dqin = wdata (combinational pass-through), bank_column = beat address.
  - The Bank writes on that same edge.
- Read timing:
  - RD_BURST drives beat addresses with bank_rd_o_wr = 0 in cycles T0+CL-1 .. T0+CL+BL-2.
  - rdata / rdata_valid are registered from bank_dqout one cycle later: rdata_valid = 1 in cycles T0+CL .. T0+CL+BL-1.
  - rdata holds its last value when rdata_valid = 0.
- Beat address for beat i: upper COLWIDTH-log2(BL) bits = cmd_col upper bits; lower log2(BL) bits = (cmd_col low bits + i) mod BL.
  - Example: BL=8, cmd_col = 0x0F6 gives 0F6, 0F7, 0F0..0F5.
  - Never carries into the upper bits; column 0x3FF wraps to 0x3F8.
- bank_row holds the latched row for the whole burst.
- Return to IDLE in the cycle after the last address beat. A new command may be accepted there, even while the final rdata beat is still being delivered; no beat is dropped or duplicated.
- bank_rd_o_wr = 0 in every state except WR_BURST.
- Reset mid-burst: immediate return to IDLE, all strobes deasserted. Beats already written remain in the Bank; unissued beats are abandoned.
- cmd_valid while not ready is ignored (no queueing); the requester holds it.

Optional Feature:
- Macro: BANK_BURST_CHOP_EN.
- Defined: adds input port cmd_bc (1 bit), latched at T0.
  - cmd_bc = 1 runs a BL/2-beat burst; wrap is within the BL/2-aligned block.
  - Latencies are unchanged; return to IDLE is BL/2 beats earlier.
  - Requires BL >= 4.
- Undefined: no cmd_bc port; every burst is BL beats.

Test Plan:
1. Reset mid-write burst (after 3 beats, BL=8) -> outputs zero immediately; cmd_ready = 1 after release; beats 0-2 persist in the Bank, beats 3-7 are unchanged.
2. Write row 3, col 0x010, wdata 1..8 (CWL=4), then read same address (CL=5):
   - wr_data_req high in cycles T0+4..T0+11.
   - rdata_valid high in cycles T1+5..T1+12, returning 1..8 in order.
3. Read at col 0x0F6 after writing 0x0F0..0x0F7 with values 0..7 -> rdata = 6, 7, 0, 1, 2, 3, 4, 5; bank_column never equals 0x0F8.
4. Write at col 0x3FF -> bank_column sequence 3FF, 3F8..3FE; 0x000 never driven.
5. Back-to-back read then write, second cmd_valid held -> second accepted in the cycle after the last read address; all 8 read beats valid; bank_rd_o_wr never 1 during a read beat.
6. With BANK_BURST_CHOP_EN, cmd_bc = 1, col 0x006 -> 4 beats at 006, 007, 004, 005; cmd_ready returns 4 cycles earlier than for BL=8.
